// File: rtl/muldiv_sequencer.sv
// Iterative unsigned multiply / divide / remainder sequencer that stalls the pipeline while busy.
// Optional macro MULDIV_FAST_MUL_EN replaces the shift-add multiply with a single-cycle multiply.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       alu_op,
    input  logic             flush,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_RSD = 3'b100;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state, state_next;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q;
    logic [CW-1:0]    cnt;

    logic             accept, iterate, write_res, zero_div, last;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] mul_acc_next, div_rem_next, div_quot_next;
    logic [WIDTH:0]   rem_sh;
    logic             rem_ge;

    // a_q doubles as multiplicand (shifts left) or dividend/quotient (shifts left); acc_q is product or remainder
    always_comb begin
        mul_acc_next  = acc_q + (b_q[0] ? a_q : '0);
        rem_sh        = {acc_q, a_q[WIDTH-1]};
        rem_ge        = (rem_sh >= {1'b0, b_q});
        div_rem_next  = rem_ge ? WIDTH'(rem_sh - {1'b0, b_q}) : rem_sh[WIDTH-1:0];
        div_quot_next = {a_q[WIDTH-2:0], rem_ge};
        last          = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        accept     = 1'b0;
        iterate    = 1'b0;
        write_res  = 1'b0;
        zero_div   = 1'b0;
        res_next   = '0;
        case (state)
            IDLE: begin
                if (start && !flush && (alu_op == OP_MUL || alu_op == OP_DIV || alu_op == OP_RSD)) begin
                    accept = 1'b1;
                    stall  = 1'b1;
                    if (alu_op == OP_MUL) begin
`ifdef MULDIV_FAST_MUL_EN
                        state_next = DONE;
                        write_res  = 1'b1;
                        res_next   = op_a * op_b;
`else
                        state_next = MUL;
`endif
                    end else begin
                        state_next = DIV;
                    end
                end
            end
            MUL: begin
                if (flush) begin
                    state_next = IDLE;
                end else begin
                    stall   = 1'b1;
                    iterate = 1'b1;
                    if (last) begin
                        state_next = DONE;
                        write_res  = 1'b1;
                        res_next   = mul_acc_next;
                    end
                end
            end
            DIV: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (b_q == '0) begin
                    // Zero divisor skips the iterations: quotient saturates, remainder is the dividend
                    stall      = 1'b1;
                    state_next = DONE;
                    write_res  = 1'b1;
                    zero_div   = 1'b1;
                    res_next   = (op_q == OP_RSD) ? a_q : '1;
                end else begin
                    stall   = 1'b1;
                    iterate = 1'b1;
                    if (last) begin
                        state_next = DONE;
                        write_res  = 1'b1;
                        res_next   = (op_q == OP_RSD) ? div_rem_next : div_quot_next;
                    end
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt      <= '0;
            result   <= '0;
            div_zero <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= alu_op;
                a_q   <= op_a;
                b_q   <= op_b;
                acc_q <= '0;
                cnt   <= '0;
            end else if (iterate) begin
                cnt <= cnt + 1'b1;
                if (state == MUL) begin
                    acc_q <= mul_acc_next;
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                end else begin
                    acc_q <= div_rem_next;
                    a_q   <= div_quot_next;
                end
            end
            if (write_res) begin
                result   <= res_next;
                div_zero <= zero_div;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: fixed vector table, random operations against an
// arithmetic reference model, and hand sequences for flush, reset and DONE-cycle corner cases.
module tb_muldiv_sequencer;
    localparam int WIDTH = 32;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_RSD = 3'b100;

    logic             clk = 1'b0;
    logic             rst, start, flush;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] op_a, op_b, result;
    logic             stall, done, div_zero;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] res;
        logic             dz;
    } vec_t;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .flush(flush),
        .op_a(op_a), .op_b(op_b), .stall(stall), .done(done),
        .result(result), .div_zero(div_zero)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_result(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                                       input logic [WIDTH-1:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            OP_MUL:  return p[WIDTH-1:0];
            OP_DIV:  return (b == 0) ? '1 : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_latency(input logic [2:0] op, input logic [WIDTH-1:0] b);
        if (op == OP_MUL) begin
`ifdef MULDIV_FAST_MUL_EN
            return 1;
`else
            return WIDTH + 1;
`endif
        end
        return (b == 0) ? 2 : WIDTH + 1;
    endfunction

    // Launches one operation, scrambles the inputs after accept, and checks timing and result
    task automatic run_op(input string name, input logic [2:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp_res, input logic exp_dz);
        int cyc;
        int stall_bad;
        start = 1'b1; alu_op = op; op_a = a; op_b = b; flush = 1'b0;
        #1;
        check({name, ".stall_accept"}, stall, 1);
        cyc = 0;
        stall_bad = 0;
        while (cyc < 60) begin
            tick();
            cyc++;
            start = 1'b0; op_a = $urandom; op_b = $urandom; alu_op = 3'($urandom);
            #1;
            if (done) break;
            if (!stall) stall_bad++;
        end
        check({name, ".latency"}, cyc, model_latency(op, b));
        check({name, ".stall_busy"}, stall_bad, 0);
        check({name, ".result"}, result, exp_res);
        check({name, ".div_zero"}, div_zero, exp_dz);
        check({name, ".stall_done"}, stall, 0);
        tick();
        #1;
        check({name, ".done_pulse"}, done, 0);
        check({name, ".result_hold"}, result, exp_res);
    endtask

    task automatic count_done(input string name, input int cycles, input logic [WIDTH-1:0] exp_res,
                              input logic exp_dz);
        int pulses;
        int stalls;
        pulses = 0;
        stalls = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done) pulses++;
            if (stall) stalls++;
        end
        check({name, ".no_done"}, pulses, 0);
        check({name, ".no_stall"}, stalls, 0);
        check({name, ".result_kept"}, result, exp_res);
        check({name, ".div_zero_kept"}, div_zero, exp_dz);
    endtask

    initial begin
        vec_t vecs[12];
        vecs[0]  = '{OP_MUL, 32'd7,          32'd6,          32'd42,         1'b0};
        vecs[1]  = '{OP_DIV, 32'd100,        32'd7,          32'd14,         1'b0};
        vecs[2]  = '{OP_RSD, 32'd100,        32'd7,          32'd2,          1'b0};
        vecs[3]  = '{OP_DIV, 32'h12345678,   32'd0,          32'hFFFFFFFF,   1'b1};
        vecs[4]  = '{OP_RSD, 32'h12345678,   32'd0,          32'h12345678,   1'b1};
        vecs[5]  = '{OP_MUL, 32'hFFFFFFFF,   32'd2,          32'hFFFFFFFE,   1'b0};
        vecs[6]  = '{OP_MUL, 32'd1000,       32'd1000,       32'd1000000,    1'b0};
        vecs[7]  = '{OP_DIV, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   1'b0};
        vecs[8]  = '{OP_RSD, 32'd5,          32'd9,          32'd5,          1'b0};
        vecs[9]  = '{OP_DIV, 32'd0,          32'd3,          32'd0,          1'b0};
        vecs[10] = '{OP_MUL, 32'h00010000,   32'h00010000,   32'd0,          1'b0};
        vecs[11] = '{OP_DIV, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          1'b0};

        rst = 1'b0; start = 1'b0; flush = 1'b0; alu_op = 3'b000; op_a = '0; op_b = '0;
        tick();
        tick();
        check("reset.stall", stall, 0);
        check("reset.done", done, 0);
        check("reset.result", result, 0);
        check("reset.div_zero", div_zero, 0);

        // Release reset and request immediately: the first edge after release must accept
        rst = 1'b1;
        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].dz);

        for (int i = 0; i < 24; i++) begin
            logic [2:0]       op;
            logic [WIDTH-1:0] a, b;
            int sel;
            sel = $urandom_range(0, 2);
            op  = (sel == 0) ? OP_MUL : (sel == 1) ? OP_DIV : OP_RSD;
            a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom);
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = 32'($urandom_range(1, 15));
                default: b = 32'($urandom);
            endcase
            run_op($sformatf("rand%0d", i), op, a, b, model_result(op, a, b), (op != OP_MUL) && (b == 0));
        end

        // Flush during DIV: stall drops in the flush cycle, no done, result untouched
        run_op("pre_flush", OP_MUL, 32'd3, 32'd5, 32'd15, 1'b0);
        start = 1'b1; alu_op = OP_DIV; op_a = 32'd100; op_b = 32'd7;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start = 1'b0;
        end
        flush = 1'b1;
        #1;
        check("flush.stall_same_cycle", stall, 0);
        tick();
        flush = 1'b0;
        #1;
        check("flush.idle_stall", stall, 0);
        check("flush.idle_done", done, 0);
        count_done("flush", 40, 32'd15, 1'b0);

        // Start with flush in IDLE, and start with an unhandled opcode, are both ignored
        start = 1'b1; flush = 1'b1; alu_op = OP_MUL; op_a = 32'd9; op_b = 32'd9;
        #1;
        check("flush_start.stall", stall, 0);
        tick();
        start = 1'b0; flush = 1'b0;
        count_done("flush_start", 40, 32'd15, 1'b0);
        start = 1'b1; alu_op = 3'b000;
        #1;
        check("badop.stall", stall, 0);
        tick();
        start = 1'b0;
        count_done("badop", 40, 32'd15, 1'b0);

        // Start asserted during the DONE cycle of a zero-divisor DIV must be dropped
        start = 1'b1; alu_op = OP_DIV; op_a = 32'd9; op_b = 32'd0;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; alu_op = OP_MUL; op_a = 32'd2; op_b = 32'd2;
        #1;
        check("done_start.done", done, 1);
        check("done_start.stall", stall, 0);
        tick();
        start = 1'b0;
        #1;
        check("done_start.not_accepted", stall, 0);
        count_done("done_start", 40, 32'hFFFFFFFF, 1'b1);

        // Reset in the middle of a MUL clears everything and leaves no done behind
        start = 1'b1; alu_op = OP_MUL; op_a = 32'd7; op_b = 32'd6;
        for (int c = 1; c <= 5; c++) begin
            tick();
            start = 1'b0;
        end
        rst = 1'b0;
        #1;
        check("midreset.stall", stall, 0);
        check("midreset.done", done, 0);
        check("midreset.result", result, 0);
        check("midreset.div_zero", div_zero, 0);
        tick();
        rst = 1'b1;
        count_done("midreset", 40, 32'd0, 1'b0);
        run_op("post_reset", OP_MUL, 32'd3, 32'd5, 32'd15, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset; state is cleared while low.
REQ-004 start  in  1  request from execute stage; sampled only in IDLE.
REQ-005 alu_op  in  3  ALU operation code: 3'b010 MUL, 3'b011 DIV, 3'b100 RSD (remainder); all other codes are not handled by this block.
REQ-006 flush  in  1  pipeline flush from a taken jump (SI/SCI/SCD); aborts an operation in progress.
REQ-007 op_a, op_b  in  WIDTH  unsigned operands; op_a is the multiplicand/dividend, op_b is the multiplier/divisor.
REQ-008 stall  out  1  freezes the fetch, decode and execute stages while high.
REQ-009 done  out  1  one-cycle pulse; result is valid in that cycle.
REQ-010 result  out  WIDTH  low WIDTH bits of the product, the quotient, or the remainder.
REQ-011 div_zero  out  1  high together with done when DIV/RSD had op_b == 0.

Function
REQ-012 The FSM SHALL have the states IDLE, MUL, DIV and DONE.
REQ-013 Accept condition: state IDLE, start=1, flush=0, alu_op in {010,011,100}. Any other start is ignored and the state stays IDLE.
REQ-014 On accept, the block SHALL latch the operands and alu_op, clear the iteration counter, and go to MUL (for 010) or DIV (for 011/100).
REQ-015 stall SHALL be combinational: high in the accept cycle and throughout MUL and DIV; low in IDLE (when no accept) and in DONE.
REQ-016 MUL SHALL be shift-add, one multiplier bit per cycle, for exactly WIDTH cycles, then go to DONE.
REQ-017 DIV SHALL be restoring division, one quotient bit per cycle, for exactly WIDTH cycles, then go to DONE.
REQ-018 Iterative latency: accept at cycle 0, iterations in cycles 1..WIDTH, done=1 in cycle WIDTH+1.
REQ-019 Division by zero: the iterations are skipped and the FSM goes from DIV to DONE at cycle 2. In that case quotient = all ones, remainder = op_a, div_zero = 1.
REQ-020 DONE SHALL last one cycle, then return to IDLE. result and div_zero SHALL hold their values until the next done; done SHALL be 0 outside DONE.
REQ-021 No new request is accepted in DONE; start asserted in DONE SHALL be ignored.
REQ-022 flush=1 in MUL or DIV SHALL return the FSM to IDLE on the next edge, with no done, and result unchanged. stall SHALL drop in that same flush cycle.
REQ-023 flush=1 together with start in IDLE SHALL block the accept.
REQ-024 The iteration counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL NOT wrap before the terminal count WIDTH-1.
REQ-025 All arithmetic is unsigned. The product is truncated to WIDTH bits with no overflow flag.

Reset
REQ-026 With rst low: state=IDLE, stall=0, done=0, result=0, div_zero=0, counter=0, latched operands=0.
REQ-027 Reset asserted mid-operation SHALL abort the operation immediately, with no done pulse after release.
REQ-028 After rst deasserts, the first accept is possible on the first rising edge.

Configuration
REQ-029 Macro MULDIV_FAST_MUL_EN: when defined, MUL is a single-cycle WIDTH x WIDTH multiply and the FSM goes IDLE -> DONE directly, with done at cycle 1 and stall high only in the accept cycle.
REQ-030 Without MULDIV_FAST_MUL_EN, MUL is iterative per REQ-016/018. DIV/RSD behaviour is the same in both builds.

Verification (WIDTH=32, no macro unless stated)
REQ-031 MUL op_a=7, op_b=6 -> done at cycle 33, result=42, stall high in cycles 0..32.
REQ-032 DIV 100/7 -> result=14 at cycle 33; RSD 100/7 -> result=2, div_zero=0.
REQ-033 DIV 0x12345678/0 -> done at cycle 2, result=0xFFFFFFFF, div_zero=1; RSD with the same operands -> result=0x12345678.
REQ-034 MUL 0xFFFFFFFF x 2 -> result=0xFFFFFFFE. start with alu_op=000 -> no stall, no done.
REQ-035 DIV accepted, flush at cycle 10 -> stall=0 in cycle 10, IDLE at cycle 11, no done. rst low at cycle 5 of a MUL -> all outputs 0, no done.
REQ-036 With MULDIV_FAST_MUL_EN: MUL 1000 x 1000 -> done at cycle 1, result=1000000.
